// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source interrupt controller for the CPU interrupt input.
// Sources are synchronized, rising-edge detected and latched into a pending
// register; masked pending bits raise a registered irq. The CPU reaches the
// PEND/MASK/ACK/ID registers through a small memory-mapped window.
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  src,
    input  logic        cs,
    input  logic        memwrite,
    input  logic [1:0]  sel,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [1:0] SEL_PEND = 2'd0;
    localparam logic [1:0] SEL_MASK = 2'd1;
    localparam logic [1:0] SEL_ACK  = 2'd2;
    localparam logic [1:0] SEL_ID   = 2'd3;

    logic [3:0] src_p0;      // first synchronizer flop
    logic [3:0] src_p1;      // second synchronizer flop (safe to use)
    logic [3:0] src_p2;      // previous synchronized level, for edge detect
    logic [3:0] src_rise;

    logic [3:0] pend;
    logic [3:0] ovf;
    logic [3:0] mask;

    logic       wr_en;
    logic [3:0] pend_set;
    logic [3:0] pend_clr;
    logic [3:0] ovf_clr;

    logic [3:0] active;
    logic [1:0] id;
    logic       valid;

    // Upper store-data bits have no register behind them.
    logic       wdata_unused;
    assign wdata_unused = ^writedata[31:8];

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

    // ---- stage p0..p2: synchronize sources and keep one level of history
    // Shift each source through two synchronizer flops plus one history flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_p0 <= 4'h0;
            src_p1 <= 4'h0;
            src_p2 <= 4'h0;
        end else begin
            src_p0 <= src;
            src_p1 <= src_p0;
            src_p2 <= src_p1;
        end
    end

    // A held-high source yields a single rise; the history flop resets to 0
    // so a source already high at reset release still produces one edge.
    assign src_rise = src_p1 & ~src_p2;

    // ---- stage p3: pending / overflow / mask registers
    // Decode CPU stores into per-bit set and clear requests.
    always_comb begin
        wr_en    = cs & memwrite;
        pend_set = src_rise;
        pend_clr = 4'h0;
        ovf_clr  = 4'h0;
        if (wr_en && sel == SEL_PEND) pend_set = src_rise | writedata[3:0];
        if (wr_en && sel == SEL_ACK) begin
            pend_clr = writedata[3:0];
            ovf_clr  = writedata[7:4];
        end
    end

    // Update pending, overflow and mask; a set always beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 4'h0;
            ovf  <= 4'h0;
            mask <= 4'h0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
            // An edge landing on a pending bit that is being acknowledged in
            // the same cycle is treated as the new occurrence, not a loss.
            ovf  <= (ovf & ~ovf_clr) | (src_rise & pend & ~pend_clr);
            if (wr_en && sel == SEL_MASK) mask <= writedata[3:0];
        end
    end

    // ---- stage p4: interrupt request
    assign active = pend & mask;
    assign valid  = |active;
    assign id     = lowest_idx(active);

    // Register the request so it changes one edge after pend or mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= valid;
    end

    // Side-effect-free read mux, zero when the window is not selected.
    always_comb begin
        readdata = 32'h0;
        if (cs) begin
            case (sel)
                SEL_PEND: readdata = {24'h0, ovf, pend};
                SEL_MASK: readdata = {28'h0, mask};
                SEL_ACK:  readdata = 32'h0;
                SEL_ID:   readdata = {23'h0, valid, 6'h0, id};
                default:  readdata = 32'h0;
            endcase
        end
    end

endmodule
